regfile_processor: RTL and testbench
====================================

# regfile_processor

Parametrised successor of the single-width register-file instruction processor. It executes one 3-bit instruction at a time against an internal NREGS x DATA_W register file and takes instructions through a valid/ready handshake. Results return through a separate valid/ready response channel. It adds reset, backpressure, configurable ALU latency and a carry/borrow flag, and replaces the free-running done toggle of the previous generation.

## Interface
- DATA_W, 16: register and immediate width; must be at least 2.
- NREGS, 32: register count; power of 2, at least 2; ADDR_W = $clog2(NREGS).
- ALU_LAT, 16: EXEC cycles for ops 101/110/111; must be at least 1.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept an instruction.
- instr  in  3  opcode.
- rs1, rs2  in  ADDR_W  read addresses.
- rd  in  ADDR_W  write address.
- imm  in  DATA_W  immediate value or shift amount.
- resp_valid  out  1  response held on resp_data1/resp_data2/resp_flag.
- resp_ready  in  1  consumer accepts the response.
- resp_data1, resp_data2  out  DATA_W  response payload.
- resp_flag  out  1  carry (ADD) or borrow (SUB), otherwise 0.

## Operation
- States: IDLE, READ, EXEC, RESP.
- instr_ready = (state==IDLE).
- Accept on an edge with instr_valid && instr_ready. At that edge instr, rs1, rs2, rd and imm are captured, and the inputs are don't-care afterwards. Next state is READ.
- READ, one cycle: op1<=regs[rs1], op2<=regs[rs2].
  - Ops 000, 011 and 100 also perform regs[rd]<=imm on the same edge. This is read-before-write: op1/op2 hold the old values even when rs==rd.
  - Ops 000–100 then go to RESP.
  - Ops 101–111 go to EXEC, with the counter loaded to ALU_LAT-1.
- EXEC: the counter decrements each cycle. On the edge where the counter is 0:
  - regs[rd]<=result;
  - resp_data1<=result;
  - go to RESP.
- RESP: resp_valid=1 and the payload is held stable until resp_ready. On the handshake edge the block returns to IDLE and resp_valid falls.
- Opcodes and payload (resp_data2=0 and resp_flag=0 unless stated otherwise):
  - 000 WRITE: rd<=imm; data1=imm.
  - 001 READ: data1=regs[rs1].
  - 010 READ2: data1=regs[rs1], data2=regs[rs2].
  - 011 WRITE_READ: rd<=imm; data1=old regs[rs1].
  - 100 WRITE_READ2: rd<=imm; data1/data2 = old regs[rs1]/regs[rs2].
  - 101 ADD: result = (op1+op2) mod 2^DATA_W; flag = carry-out.
  - 110 SUB: result = (op1-op2) mod 2^DATA_W; flag = 1 when op1<op2 unsigned.
  - 111 SHL: result = op1 << imm, with imm treated as unsigned full width; result = 0 when imm >= DATA_W.
- All arithmetic is unsigned and truncated to DATA_W.
- rd may equal rs1 or rs2. Operands are always pre-write values.

## Timing
- Reset (asynchronous, effective immediately, no clock needed):
  - state=IDLE;
  - all registers 0;
  - instr_ready=1 once rst deasserts;
  - resp_valid=0, resp_data1=0, resp_data2=0, resp_flag=0;
  - counter=0.
- Reset mid-operation aborts the instruction. A pending ALU write is discarded. A WRITE whose READ edge coincides with reset assertion does not take effect.
- Latency, counted from the accept edge to the first cycle with resp_valid=1:
  - ops 000–100: 2 edges;
  - ops 101–111: 2+ALU_LAT edges.
- Register-file writes are visible to any later instruction's READ.
- With resp_ready tied high, each instruction occupies:
  - ops 000–100: 3 cycles accept-to-accept;
  - ops 101–111: 3+ALU_LAT cycles.
- Backpressure: resp_valid stays 1 and the payload is frozen for any number of cycles with resp_ready=0. No new instruction is accepted (instr_ready=0) during this time.
- instr_valid while busy is ignored and not queued. The source must hold it until instr_ready.
- resp_ready while resp_valid=0 has no effect.
- The counter never wraps. ALU_LAT=1 gives one EXEC cycle.

## Test plan
All scenarios use DATA_W=16, NREGS=32, ALU_LAT=16.
- Reset, then WRITE rd=3 imm=0x1234, then READ rs1=3 → data1=0x1234. resp_valid appears 2 edges after each accept. instr_ready=0 while busy.
- WRITE r1=0xFFFF, WRITE r2=0x0002, ADD rs1=1 rs2=2 rd=1 → data1=0x0001, flag=1, response 18 edges after accept. A following READ2 rs1=1 rs2=2 → data1=0x0001, data2=0x0002.
- SUB r4=0x0003, r5=0x0005 (r4−r5) → data1=0xFFFE, flag=1. SHL r6=0x8001 by imm=1 → 0x0002; by imm=20 → 0x0000.
- WRITE_READ rd=7 rs1=7 imm=0xAAAA with r7=0x5555 → data1=0x5555. A subsequent READ r7 → 0xAAAA.
- Hold resp_ready=0 for 10 cycles during an ADD response → payload stable, instr_valid ignored. Release → one handshake, then instr_ready=1 on the next cycle.
- Assert rst at EXEC cycle 8 of ADD rd=9 → r9 reads 0 afterward, resp_valid=0 immediately, and normal operation resumes after deassertion.

Source files
------------

// File: rtl/regfile_processor.sv
// Register-file instruction processor: one 3-bit instruction at a time against
// an NREGS x DATA_W register file. Instructions and responses use valid/ready handshakes.
module regfile_processor #(
  parameter  int DATA_W  = 16,
  parameter  int NREGS   = 32,
  parameter  int ALU_LAT = 16,
  localparam int ADDR_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] imm,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data1,
  output logic [DATA_W-1:0] resp_data2,
  output logic              resp_flag
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [DATA_W-1:0] SH_LIM = DATA_W'(DATA_W);

  localparam logic [2:0] OP_WRITE  = 3'b000;
  localparam logic [2:0] OP_READ   = 3'b001;
  localparam logic [2:0] OP_READ2  = 3'b010;
  localparam logic [2:0] OP_WREAD  = 3'b011;
  localparam logic [2:0] OP_WREAD2 = 3'b100;
  localparam logic [2:0] OP_ADD    = 3'b101;
  localparam logic [2:0] OP_SUB    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_rs1, r_rs2, r_rd;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_op1, r_op2;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_regs [NREGS];
  logic [DATA_W-1:0]   r_d1, r_d2;
  logic                r_flag;

  logic                w_accept;
  logic                w_alu_op;
  logic                w_writes_imm;
  logic [DATA_W:0]     w_sum, w_diff;
  logic [DATA_W-1:0]   w_shl;
  logic [DATA_W-1:0]   w_result;
  logic                w_res_flag;

  assign instr_ready  = (r_state == S_IDLE);
  assign resp_valid   = (r_state == S_RESP);
  assign resp_data1   = r_d1;
  assign resp_data2   = r_d2;
  assign resp_flag    = r_flag;
  assign w_accept     = instr_valid && (r_state == S_IDLE);
  assign w_alu_op     = (r_op >= OP_ADD);
  assign w_writes_imm = (r_op == OP_WRITE) || (r_op == OP_WREAD) || (r_op == OP_WREAD2);

  // Extra MSB carries the ADD carry-out / SUB borrow.
  assign w_sum  = {1'b0, r_op1} + {1'b0, r_op2};
  assign w_diff = {1'b0, r_op1} - {1'b0, r_op2};
  assign w_shl  = (r_imm >= SH_LIM) ? '0 : (r_op1 << r_imm);

  always_comb begin
    w_result   = w_shl;
    w_res_flag = 1'b0;
    case (r_op)
      OP_ADD: begin w_result = w_sum[DATA_W-1:0];  w_res_flag = w_sum[DATA_W];  end
      OP_SUB: begin w_result = w_diff[DATA_W-1:0]; w_res_flag = w_diff[DATA_W]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (instr_valid)   w_next = S_READ;
      S_READ: w_next = w_alu_op ? S_EXEC : S_RESP;
      S_EXEC: if (r_cnt == '0)   w_next = S_RESP;
      S_RESP: if (resp_ready)    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
      r_imm  <= '0;
      r_op1  <= '0;
      r_op2  <= '0;
      r_cnt  <= '0;
      r_d1   <= '0;
      r_d2   <= '0;
      r_flag <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= instr;
        r_rs1 <= rs1;
        r_rs2 <= rs2;
        r_rd  <= rd;
        r_imm <= imm;
      end
      if (r_state == S_READ) begin
        // Operands and payload take pre-write values even when rs == rd.
        r_op1 <= r_regs[r_rs1];
        r_op2 <= r_regs[r_rs2];
        if (w_writes_imm) r_regs[r_rd] <= r_imm;
        if (w_alu_op) begin
          r_cnt <= CNT_W'(ALU_LAT - 1);
        end else begin
          r_flag <= 1'b0;
          r_d1   <= (r_op == OP_WRITE) ? r_imm : r_regs[r_rs1];
          r_d2   <= (r_op == OP_READ2 || r_op == OP_WREAD2) ? r_regs[r_rs2] : '0;
        end
      end
      if (r_state == S_EXEC) begin
        if (r_cnt == '0) begin
          r_regs[r_rd] <= w_result;
          r_d1         <= w_result;
          r_d2         <= '0;
          r_flag       <= w_res_flag;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_processor.sv
// Bench for regfile_processor: table of instructions with hand-computed results,
// a response scoreboard, plus backpressure and mid-operation reset sequences.
module tb_regfile_processor;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready;
  logic [2:0]  instr;
  logic [4:0]  rs1, rs2, rd;
  logic [15:0] imm;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_data1, resp_data2;
  logic        resp_flag;

  always #5 clk = ~clk;

  regfile_processor #(.DATA_W(16), .NREGS(32), .ALU_LAT(16)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data1(resp_data1), .resp_data2(resp_data2), .resp_flag(resp_flag)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] imm;
    logic [15:0] d1, d2;
    logic        flag;
    logic [7:0]  lat;
  } vec_t;

  typedef struct packed {
    logic [15:0] d1, d2;
    logic        flag;
  } rsp_t;

  rsp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [4:0] a, b, d,
                              input logic [15:0] im, input logic [15:0] e1, e2,
                              input logic ef);
    vec_t v;
    v.op = op; v.rs1 = a; v.rs2 = b; v.rd = d; v.imm = im;
    v.d1 = e1; v.d2 = e2; v.flag = ef;
    v.lat = (op >= 3'd5) ? 8'd18 : 8'd2;
    return v;
  endfunction

  // Drive one instruction, verify latency/busy, then score the response.
  task automatic issue(input vec_t v, input bit full_check);
    int   n, w;
    bit   busy_ok;
    rsp_t e;
    sb.push_back({v.d1, v.d2, v.flag});
    @(negedge clk);
    instr = v.op; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; imm = v.imm;
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 200) begin @(negedge clk); w++; end
    if (!instr_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 3'bx; rs1 = 'x; rs2 = 'x; rd = 'x; imm = 'x;
    n = 1;
    busy_ok = 1'b1;
    while (!resp_valid && n < 200) begin
      if (instr_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (full_check) begin
      chk($sformatf("latency op%0d", v.op), n, v.lat);
      chk("busy_ready_low", busy_ok, 1);
    end
    if (resp_valid) begin
      e = sb.pop_front();
      chk($sformatf("data1 op%0d", v.op), resp_data1, e.d1);
      chk($sformatf("data2 op%0d", v.op), resp_data2, e.d2);
      chk($sformatf("flag op%0d", v.op), resp_flag, e.flag);
    end else begin
      chk("resp_timeout", 0, 1);
      void'(sb.pop_front());
    end
    if (resp_ready) begin
      @(posedge clk); #1;
      if (full_check) begin
        chk("resp_valid_drop", resp_valid, 0);
        chk("ready_after_hs", instr_ready, 1);
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    int   w;
    logic [15:0] held;
    rst = 1'b1; instr_valid = 1'b0; resp_ready = 1'b1;
    instr = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_data1", resp_data1, 0);
    chk("rst_data2", resp_data2, 0);
    chk("rst_flag", resp_flag, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_ready", instr_ready, 1);

    // op, rs1, rs2, rd, imm, data1, data2, flag
    vecs.push_back(mk(3'd0, 0, 0, 3,  16'h1234, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(3'd1, 3, 0, 0,  16'h0000, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(3'd0, 0, 0, 1,  16'hFFFF, 16'hFFFF, 16'h0000, 0));
    vecs.push_back(mk(3'd0, 0, 0, 2,  16'h0002, 16'h0002, 16'h0000, 0));
    vecs.push_back(mk(3'd5, 1, 2, 1,  16'h0000, 16'h0001, 16'h0000, 1));
    vecs.push_back(mk(3'd2, 1, 2, 0,  16'h0000, 16'h0001, 16'h0002, 0));
    vecs.push_back(mk(3'd0, 0, 0, 4,  16'h0003, 16'h0003, 16'h0000, 0));
    vecs.push_back(mk(3'd0, 0, 0, 5,  16'h0005, 16'h0005, 16'h0000, 0));
    vecs.push_back(mk(3'd6, 4, 5, 10, 16'h0000, 16'hFFFE, 16'h0000, 1));
    vecs.push_back(mk(3'd0, 0, 0, 6,  16'h8001, 16'h8001, 16'h0000, 0));
    vecs.push_back(mk(3'd7, 6, 0, 11, 16'd1,    16'h0002, 16'h0000, 0));
    vecs.push_back(mk(3'd7, 6, 0, 12, 16'd20,   16'h0000, 16'h0000, 0));
    vecs.push_back(mk(3'd7, 6, 0, 14, 16'd15,   16'h8000, 16'h0000, 0));
    vecs.push_back(mk(3'd7, 6, 0, 14, 16'd16,   16'h0000, 16'h0000, 0));
    vecs.push_back(mk(3'd0, 0, 0, 7,  16'h5555, 16'h5555, 16'h0000, 0));
    vecs.push_back(mk(3'd3, 7, 0, 7,  16'hAAAA, 16'h5555, 16'h0000, 0));
    vecs.push_back(mk(3'd1, 7, 0, 0,  16'h0000, 16'hAAAA, 16'h0000, 0));
    vecs.push_back(mk(3'd4, 8, 7, 8,  16'h00FF, 16'h0000, 16'hAAAA, 0));
    vecs.push_back(mk(3'd2, 8, 11, 0, 16'h0000, 16'h00FF, 16'h0002, 0));
    vecs.push_back(mk(3'd5, 4, 5, 13, 16'h0000, 16'h0008, 16'h0000, 0));
    vecs.push_back(mk(3'd6, 5, 4, 13, 16'h0000, 16'h0002, 16'h0000, 0));
    vecs.push_back(mk(3'd1, 10, 0, 0, 16'h0000, 16'hFFFE, 16'h0000, 0));

    foreach (vecs[i]) issue(vecs[i], 1'b1);

    // Backpressure: ADD r4+r5 -> r15, response held 10 cycles with a competing offer.
    resp_ready = 1'b0;
    issue(mk(3'd5, 4, 5, 15, 16'h0000, 16'h0008, 16'h0000, 0), 1'b1);
    held = resp_data1;
    @(negedge clk);
    instr = 3'd0; rd = 5'd15; imm = 16'hDEAD; instr_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid c%0d", c), resp_valid, 1);
      chk($sformatf("bp_data c%0d", c), resp_data1, held);
      chk($sformatf("bp_ready c%0d", c), instr_ready, 0);
    end
    @(negedge clk);
    instr_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", resp_valid, 0);
    chk("bp_release_ready", instr_ready, 1);
    issue(mk(3'd1, 15, 0, 0, 16'h0000, 16'h0008, 16'h0000, 0), 1'b1);

    // Mid-EXEC reset of ADD rd=9.
    issue(mk(3'd0, 0, 0, 9, 16'h1111, 16'h1111, 16'h0000, 0), 1'b1);
    @(negedge clk);
    instr = 3'd5; rs1 = 5'd4; rs2 = 5'd5; rd = 5'd9; instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #1;                       // READ edge
    repeat (8) begin @(posedge clk); #1; end  // EXEC cycles
    rst = 1'b1;
    #1;
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_data1", resp_data1, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_ready", instr_ready, 1);
    repeat (20) begin
      @(posedge clk); #1;
      if (resp_valid) chk("midrst_stale_resp", resp_valid, 0);
    end
    issue(mk(3'd1, 9, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0), 1'b1);
    issue(mk(3'd2, 4, 7, 0, 16'h0000, 16'h0000, 16'h0000, 0), 1'b1);
    issue(mk(3'd0, 0, 0, 9, 16'hBEEF, 16'hBEEF, 16'h0000, 0), 1'b1);
    issue(mk(3'd1, 9, 0, 0, 16'h0000, 16'hBEEF, 16'h0000, 0), 1'b1);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
